// File: rtl/nes_clk_enable_gen_pkg.sv
// Shared types and default timing constants for the NES clock-enable generator.
// Default divide ratios are for NTSC and PAL master clocks.
package nes_clk_pkg;

  typedef enum logic {
    MODE_NTSC = 1'b0,
    MODE_PAL  = 1'b1
  } nes_mode_t;

  localparam int DEF_NTSC_PPU_DIV = 8;
  localparam int DEF_NTSC_CPU_DIV = 24;
  localparam int DEF_PAL_PPU_DIV  = 10;
  localparam int DEF_PAL_CPU_DIV  = 32;
  localparam int DEF_PPU_PHASE    = 7;
  localparam int DEF_CPU_PHASE    = 7;
  localparam int DEF_NTSC_M2_HIGH = 15;
  localparam int DEF_PAL_M2_HIGH  = 20;
  localparam int DEF_PPU_RST_CYC  = 16;
  localparam int DEF_CPU_RST_CYC  = 72;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_clk_enable_gen_if.sv
// Control inputs and enable/reset outputs of the NES timing generator.
// The slave modport is the generator; the master modport is the core consuming the enables.
interface nes_clk_enable_gen_if;
  logic en;
  logic pal;
  logic ppu_ce;
  logic cpu_ce;
  logic m2;
  logic rst_ppu;
  logic rst_cpu;
  logic pal_active;

  modport master (
    output en, pal,
    input  ppu_ce, cpu_ce, m2, rst_ppu, rst_cpu, pal_active
  );

  modport slave (
    input  en, pal,
    output ppu_ce, cpu_ce, m2, rst_ppu, rst_cpu, pal_active
  );
endinterface

// File: rtl/nes_ce_divider.sv
// Wrapping divide-by-i_div counter that emits a registered one-cycle enable
// when the count matches PHASE; o_fire is the pre-register version of that pulse.
module nes_ce_divider #(
  parameter int W     = 4,
  parameter int PHASE = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clear,
  input  logic [W-1:0] i_div,
  output logic         o_fire,
  output logic         o_ce
);

  logic [W-1:0] r_cnt;
  logic         r_ce;

  // A clear (mode change) suppresses a coincident phase match.
  assign o_fire = i_en & ~i_clear & (r_cnt == W'(PHASE));
  assign o_ce   = r_ce;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_ce <= o_fire;
      if (i_en) r_cnt <= (r_cnt >= i_div - W'(1)) ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/nes_clk_enable_gen.sv
// NES timing generator: PPU/CPU clock enables, M2 strobe and staged domain resets
// from one master clock, with run-time NTSC/PAL selection.
module nes_clk_enable_gen
  import nes_clk_pkg::*;
#(
  parameter int NTSC_PPU_DIV = DEF_NTSC_PPU_DIV,
  parameter int NTSC_CPU_DIV = DEF_NTSC_CPU_DIV,
  parameter int PAL_PPU_DIV  = DEF_PAL_PPU_DIV,
  parameter int PAL_CPU_DIV  = DEF_PAL_CPU_DIV,
  parameter int PPU_PHASE    = DEF_PPU_PHASE,
  parameter int CPU_PHASE    = DEF_CPU_PHASE,
  parameter int NTSC_M2_HIGH = DEF_NTSC_M2_HIGH,
  parameter int PAL_M2_HIGH  = DEF_PAL_M2_HIGH,
  parameter int PPU_RST_CYC  = DEF_PPU_RST_CYC,
  parameter int CPU_RST_CYC  = DEF_CPU_RST_CYC
) (
  input  logic                clk_master,
  input  logic                rst_master_n,
  nes_clk_enable_gen_if.slave bus
);

  localparam int PPU_W = $clog2(max_int(NTSC_PPU_DIV, PAL_PPU_DIV) + 1);
  localparam int CPU_W = $clog2(max_int(NTSC_CPU_DIV, PAL_CPU_DIV) + 1);
  localparam int M2_W  = $clog2(max_int(NTSC_M2_HIGH, PAL_M2_HIGH) + 1);
  localparam int SEQ_W = $clog2(CPU_RST_CYC + 1);

  nes_mode_t        r_mode;
  logic [SEQ_W-1:0] r_seq;
  logic [M2_W-1:0]  r_m2_cnt;
  logic             r_m2;
  logic             r_rst_ppu;
  logic             r_rst_cpu;

  logic             w_mode_chg;
  logic [PPU_W-1:0] w_ppu_div;
  logic [CPU_W-1:0] w_cpu_div;
  logic [M2_W-1:0]  w_m2_high;
  logic [SEQ_W-1:0] w_seq_nxt;
  logic             w_ppu_fire;
  logic             w_cpu_fire;

  assign w_mode_chg = (nes_mode_t'(bus.pal) != r_mode);
  assign w_ppu_div  = (r_mode == MODE_PAL) ? PPU_W'(PAL_PPU_DIV)  : PPU_W'(NTSC_PPU_DIV);
  assign w_cpu_div  = (r_mode == MODE_PAL) ? CPU_W'(PAL_CPU_DIV)  : CPU_W'(NTSC_CPU_DIV);
  assign w_m2_high  = (r_mode == MODE_PAL) ? M2_W'(PAL_M2_HIGH)   : M2_W'(NTSC_M2_HIGH);
  assign w_seq_nxt  = (r_seq == SEQ_W'(CPU_RST_CYC)) ? r_seq : r_seq + SEQ_W'(1);

  // PAL's 3.2 PPU:CPU ratio is non-integer, so the two domains divide independently.
  nes_ce_divider #(.W(PPU_W), .PHASE(PPU_PHASE)) u_ppu_div (
    .clk     (clk_master),
    .rst_n   (rst_master_n),
    .i_en    (bus.en),
    .i_clear (w_mode_chg),
    .i_div   (w_ppu_div),
    .o_fire  (w_ppu_fire),
    .o_ce    (bus.ppu_ce)
  );

  nes_ce_divider #(.W(CPU_W), .PHASE(CPU_PHASE)) u_cpu_div (
    .clk     (clk_master),
    .rst_n   (rst_master_n),
    .i_en    (bus.en),
    .i_clear (w_mode_chg),
    .i_div   (w_cpu_div),
    .o_fire  (w_cpu_fire),
    .o_ce    (bus.cpu_ce)
  );

  always_ff @(posedge clk_master or negedge rst_master_n) begin
    if (!rst_master_n) begin
      r_mode    <= MODE_NTSC;
      r_seq     <= '0;
      r_m2      <= 1'b0;
      r_m2_cnt  <= '0;
      r_rst_ppu <= 1'b1;
      r_rst_cpu <= 1'b1;
    end else if (w_mode_chg) begin
      r_mode    <= nes_mode_t'(bus.pal);
      r_seq     <= '0;
      r_m2      <= 1'b0;
      r_m2_cnt  <= '0;
      r_rst_ppu <= 1'b1;
      r_rst_cpu <= 1'b1;
    end else begin
      r_seq <= w_seq_nxt;
      // Releases land on the same edge that raises the domain enable.
      if (w_ppu_fire && (w_seq_nxt >= SEQ_W'(PPU_RST_CYC))) r_rst_ppu <= 1'b0;
      if (w_cpu_fire && (w_seq_nxt >= SEQ_W'(CPU_RST_CYC))) r_rst_cpu <= 1'b0;
      // r_m2_cnt counts the high cycles seen so far, including the rising one.
      if (w_cpu_fire) begin
        r_m2     <= 1'b1;
        r_m2_cnt <= M2_W'(1);
      end else if (r_m2 && bus.en) begin
        if (r_m2_cnt >= w_m2_high) r_m2 <= 1'b0;
        else                       r_m2_cnt <= r_m2_cnt + M2_W'(1);
      end
    end
  end

  assign bus.m2         = r_m2;
  assign bus.rst_ppu    = r_rst_ppu;
  assign bus.rst_cpu    = r_rst_cpu;
  assign bus.pal_active = (r_mode == MODE_PAL);

endmodule

// File: tb/tb_nes_clk_enable_gen.sv
// Self-checking bench for nes_clk_enable_gen: cycle-by-cycle comparison against a
// tick-count reference model plus directed period, release and async-reset checks.
module tb_nes_clk_enable_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nes_clk_enable_gen_if bus ();

  nes_clk_enable_gen dut (
    .clk_master   (clk),
    .rst_master_n (rst_n),
    .bus          (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int c_ppu, c_cpu, c_both, c_m2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: en-tick counts since sequence start, divided by plain modulo.
  int m_seq, m_ppu_t, m_cpu_t, m_m2_left;
  bit m_pal, m_ppu_ce, m_cpu_ce, m_m2, m_rst_ppu, m_rst_cpu;

  task automatic model_reset();
    m_seq = 0; m_ppu_t = 0; m_cpu_t = 0; m_m2_left = 0;
    m_pal = 0; m_ppu_ce = 0; m_cpu_ce = 0; m_m2 = 0; m_rst_ppu = 1; m_rst_cpu = 1;
  endtask

  task automatic model_edge(input bit en, input bit pal);
    int pdiv, cdiv, mh;
    bit fp, fc;
    if (pal != m_pal) begin
      m_pal = pal; m_seq = 0; m_ppu_t = 0; m_cpu_t = 0; m_m2_left = 0;
      m_ppu_ce = 0; m_cpu_ce = 0; m_m2 = 0; m_rst_ppu = 1; m_rst_cpu = 1;
    end else begin
      pdiv = m_pal ? 10 : 8;
      cdiv = m_pal ? 32 : 24;
      mh   = m_pal ? 20 : 15;
      fp = en && ((m_ppu_t % pdiv) == 7);
      fc = en && ((m_cpu_t % cdiv) == 7);
      if (en) begin m_ppu_t++; m_cpu_t++; end
      m_seq = (m_seq >= 72) ? 72 : m_seq + 1;
      if (fc) begin
        m_m2 = 1; m_m2_left = mh - 1;
      end else if (m_m2 && en) begin
        if (m_m2_left == 0) m_m2 = 0;
        else m_m2_left--;
      end
      m_ppu_ce = fp;
      m_cpu_ce = fc;
      if (fp && m_seq >= 16) m_rst_ppu = 0;
      if (fc && m_seq >= 72) m_rst_cpu = 0;
    end
  endtask

  function automatic logic [5:0] exp_vec();
    return {m_ppu_ce, m_cpu_ce, m_m2, m_rst_ppu, m_rst_cpu, m_pal};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.ppu_ce, bus.cpu_ce, bus.m2, bus.rst_ppu, bus.rst_cpu, bus.pal_active};
  endfunction

  task automatic clr_counts();
    c_ppu = 0; c_cpu = 0; c_both = 0; c_m2 = 0;
  endtask

  // One master edge: advance model with the inputs seen at the edge, compare, then drive next inputs.
  task automatic step(input bit en_nxt, input bit pal_nxt);
    @(posedge clk);
    model_edge(bus.en, bus.pal);
    #1;
    cyc++;
    check("outputs", 32'(dut_vec()), 32'(exp_vec()));
    c_ppu  += int'(bus.ppu_ce);
    c_cpu  += int'(bus.cpu_ce);
    c_both += int'(bus.ppu_ce & bus.cpu_ce);
    c_m2   += int'(bus.m2);
    bus.en  = en_nxt;
    bus.pal = pal_nxt;
  endtask

  initial begin
    int rel_ppu, rel_cpu;
    bit found;
    bit p;

    bus.en = 1'b1;
    bus.pal = 1'b0;
    model_reset();
    #12;
    check("reset_vec", 32'(dut_vec()), 32'h06);

    // NTSC power-up release timing.
    @(negedge clk) rst_n = 1'b1;
    rel_ppu = -1; rel_cpu = -1;
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b0);
      if (rel_ppu < 0 && !bus.rst_ppu) rel_ppu = i;
      if (rel_cpu < 0 && !bus.rst_cpu) rel_cpu = i;
    end
    check("ntsc_rst_ppu_release", 32'(rel_ppu), 32'd16);
    check("ntsc_rst_cpu_release", 32'(rel_cpu), 32'd80);

    // NTSC steady-state ratios over 240 cycles.
    clr_counts();
    for (int i = 0; i < 240; i++) step(1'b1, 1'b0);
    check("ntsc_ppu_count", 32'(c_ppu), 32'd30);
    check("ntsc_cpu_count", 32'(c_cpu), 32'd10);
    check("ntsc_coincide", 32'(c_both), 32'd10);
    check("ntsc_m2_high", 32'(c_m2), 32'd150);

    // Freeze for 37 cycles mid-period.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    clr_counts();
    for (int i = 0; i < 36; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("freeze_no_ce", 32'(c_ppu + c_cpu), 32'd0);

    // Switch to PAL around cycle 500.
    while (cyc < 499) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("mode_chg_rst", 32'({bus.rst_ppu, bus.rst_cpu, bus.pal_active}), 32'h7);
    for (int i = 0; i < 120; i++) step(1'b1, 1'b1);
    check("pal_released", 32'({bus.rst_ppu, bus.rst_cpu}), 32'h0);
    clr_counts();
    for (int i = 0; i < 160; i++) step(1'b1, 1'b1);
    check("pal_ppu_count", 32'(c_ppu), 32'd16);
    check("pal_cpu_count", 32'(c_cpu), 32'd5);
    check("pal_m2_high", 32'(c_m2), 32'd100);

    // Random en gaps and occasional mode flips.
    p = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) p = ~p;
      step($urandom_range(0, 3) != 0, p);
    end

    // Async reset while m2 and cpu_ce are both high.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, bus.pal);
      if (bus.cpu_ce && bus.m2) found = 1'b1;
    end
    check("found_cpu_ce", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vec", 32'(dut_vec()), 32'h06);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 150; i++) step($urandom_range(0, 4) != 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
